// File: rtl/rr_arbiter4.sv
// rr_arbiter4 - four-requester round-robin arbiter driving the select/enable
// pair (gnt_idx -> A, gnt_valid -> En) of a 2-to-4 decoder stage, plus the
// equivalent one-hot grant. All outputs come straight from flops.
//
// An owner keeps the grant until it drops its request. There is always one
// idle cycle between two grants.
//
// Optional feature: define RR_ARBITER4_TIMEOUT_EN to limit a continuous
// grant to MAX_HOLD cycles. A preempted owner stays as `last`, so it moves
// to the back of the search order.
module rr_arbiter4 #(
   parameter int MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       gnt_valid
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   // Reject an out-of-range hold limit at elaboration time.
   generate
      if ((MAX_HOLD < 2) || (MAX_HOLD > 256)) begin : g_max_hold_range
         $error("rr_arbiter4: MAX_HOLD must be in 2..256");
      end
   endgenerate

   // One-hot decode of the index, gated by the valid flag.
   function automatic logic [3:0] decode_gnt(input logic [1:0] idx_v, input logic valid_v);
      logic [3:0] onehot_v;
      onehot_v = 4'b0000;
      if (valid_v) begin
         onehot_v[idx_v] = 1'b1;
      end else begin
         onehot_v = 4'b0000;
      end
      return onehot_v;
   endfunction

   // Round-robin pick: scan last+1, last+2, last+3, last.
   // Returns {found, index}.
   // Scanning from the lowest priority upward lets the highest-priority hit
   // overwrite the earlier ones.
   function automatic logic [2:0] rr_pick(input logic [3:0] req_v, input logic [1:0] last_v);
      logic [2:0] res_v;
      logic [1:0] cand_v;
      res_v = 3'b000;
      for (int k = 4; k >= 1; k--) begin
         cand_v = last_v + k[1:0];
         if (req_v[cand_v]) begin
            res_v = {1'b1, cand_v};
         end else begin
            res_v = res_v;
         end
      end
      return res_v;
   endfunction

   logic [0:0] state_r;
   logic [0:0] state_nxt_s;
   logic [1:0] last_r;
   logic [1:0] last_nxt_s;
   logic [3:0] gnt_r;
   logic [3:0] gnt_nxt_s;
   logic [1:0] gnt_idx_r;
   logic [1:0] gnt_idx_nxt_s;
   logic       gnt_valid_r;
   logic       gnt_valid_nxt_s;
   logic [2:0] pick_s;
   logic       timeout_s;

`ifdef RR_ARBITER4_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   logic [7:0] hold_cnt_r;
   logic [7:0] hold_cnt_nxt_s;

   // Hold counter: cleared on entry to GRANT, counts each GRANT cycle.
   always_comb begin
      hold_cnt_nxt_s = hold_cnt_r;
      if ((state_r == ST_IDLE) && pick_s[2]) begin
         hold_cnt_nxt_s = 8'd0;
      end else if (state_r == ST_GRANT) begin
         hold_cnt_nxt_s = hold_cnt_r + 8'd1;
      end else begin
         hold_cnt_nxt_s = hold_cnt_r;
      end
   end

   // Hold counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt_r <= 8'd0;
      end else begin
         hold_cnt_r <= hold_cnt_nxt_s;
      end
   end

   assign timeout_s = (state_r == ST_GRANT) && (hold_cnt_r == HOLD_LAST);
`else
   assign timeout_s = 1'b0;
`endif

   assign pick_s = rr_pick(req, last_r);

   // Next-state logic: arbitrate in IDLE, hold or release in GRANT.
   always_comb begin
      state_nxt_s     = state_r;
      last_nxt_s      = last_r;
      gnt_idx_nxt_s   = gnt_idx_r;
      gnt_valid_nxt_s = gnt_valid_r;
      case (state_r)
         ST_IDLE: begin
            if (pick_s[2]) begin
               state_nxt_s     = ST_GRANT;
               gnt_idx_nxt_s   = pick_s[1:0];
               last_nxt_s      = pick_s[1:0];
               gnt_valid_nxt_s = 1'b1;
            end else begin
               state_nxt_s     = ST_IDLE;
               gnt_valid_nxt_s = 1'b0;
            end
         end
         ST_GRANT: begin
            if (!req[gnt_idx_r] || timeout_s) begin
               state_nxt_s     = ST_IDLE;
               gnt_valid_nxt_s = 1'b0;
            end else begin
               state_nxt_s     = ST_GRANT;
               gnt_valid_nxt_s = 1'b1;
            end
         end
         default: begin
            state_nxt_s     = ST_IDLE;
            gnt_valid_nxt_s = 1'b0;
         end
      endcase
      gnt_nxt_s = decode_gnt(gnt_idx_nxt_s, gnt_valid_nxt_s);
   end

   // State, pointer and output registers. All outputs update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         last_r      <= 2'b11;
         gnt_r       <= 4'b0000;
         gnt_idx_r   <= 2'b00;
         gnt_valid_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         last_r      <= last_nxt_s;
         gnt_r       <= gnt_nxt_s;
         gnt_idx_r   <= gnt_idx_nxt_s;
         gnt_valid_r <= gnt_valid_nxt_s;
      end
   end

   assign gnt       = gnt_r;
   assign gnt_idx   = gnt_idx_r;
   assign gnt_valid = gnt_valid_r;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed testbench for rr_arbiter4. Expected values are hand-derived.
// Build with RR_ARBITER4_TIMEOUT_EN defined to exercise the hold limit
// (MAX_HOLD=4). Without it, the bench runs the 100-cycle hold sequence.
module tb_rr_arbiter4;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_valid;

   int checks;
   int failures;

   rr_arbiter4 #(.MAX_HOLD(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Check an active grant: one-hot, index and valid.
   task automatic chk_grant(input string tag, input logic [3:0] exp_gnt, input logic [1:0] exp_idx);
      checks++;
      assert ({gnt, gnt_idx, gnt_valid} === {exp_gnt, exp_idx, 1'b1})
      else begin
         failures++;
         $error("FAIL %s: gnt=%b idx=%b valid=%b, expected gnt=%b idx=%b valid=1",
                tag, gnt, gnt_idx, gnt_valid, exp_gnt, exp_idx);
      end
   endtask

   // Check an idle cycle: no grant.
   task automatic chk_idle(input string tag);
      checks++;
      assert ({gnt, gnt_valid} === {4'b0000, 1'b0})
      else begin
         failures++;
         $error("FAIL %s: gnt=%b valid=%b, expected gnt=0000 valid=0", tag, gnt, gnt_valid);
      end
   endtask

   // Check the full reset state, including the index.
   task automatic chk_reset(input string tag);
      checks++;
      assert ({gnt, gnt_idx, gnt_valid} === {4'b0000, 2'b00, 1'b0})
      else begin
         failures++;
         $error("FAIL %s: gnt=%b idx=%b valid=%b, expected 0000/00/0", tag, gnt, gnt_idx, gnt_valid);
      end
   endtask

   initial begin
      logic [3:0] exp_g;
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      req      = 4'b0000;
      #1;
      chk_reset("reset_initial");
      @(negedge clk);
      rst_n = 1'b1;

      // Single request: a grant to 2 is held while req[2] stays high.
      req = 4'b0100;
      step();
      chk_grant("single_grant", 4'b0100, 2'd2);
      step();
      chk_grant("single_hold1", 4'b0100, 2'd2);
      step();
      chk_grant("single_hold2", 4'b0100, 2'd2);
      req = 4'b0000;
      step();
      chk_idle("single_release");
      step();
      chk_idle("single_stay_idle");

      // Reset mid-grant. last=2, so requester 3 is granted first.
      req = 4'b1111;
      step();
      chk_grant("pre_reset_grant", 4'b1000, 2'd3);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset("reset_async_mid_grant");
      step();
      chk_reset("reset_held_over_edge");
      @(negedge clk);
      rst_n = 1'b1;

      // Fairness: each owner holds for 2 cycles, then drops its bit for 1 cycle.
      for (int i = 0; i < 5; i++) begin
         exp_g = 4'b0001 << (i % 4);
         step();
         chk_grant("fair_grant", exp_g, 2'(i % 4));
         step();
         chk_grant("fair_hold", exp_g, 2'(i % 4));
         req = ~exp_g;
         step();
         chk_idle("fair_gap");
         req = 4'b1111;
      end

      // No preemption: req[0] toggles while 1 owns the grant. last=0 here.
      req = 4'b0010;
      step();
      chk_grant("nopre_grant", 4'b0010, 2'd1);
      req = 4'b0011;
      step();
      chk_grant("nopre_toggle1", 4'b0010, 2'd1);
      req = 4'b0010;
      step();
      chk_grant("nopre_toggle2", 4'b0010, 2'd1);
      req = 4'b0011;
      step();
      chk_grant("nopre_toggle3", 4'b0010, 2'd1);
      req = 4'b0001;
      step();
      chk_idle("nopre_release_gap");
      step();
      chk_grant("nopre_next_owner", 4'b0001, 2'd0);
      req = 4'b0000;
      step();
      chk_idle("nopre_done");

`ifdef RR_ARBITER4_TIMEOUT_EN
      // Make last=1 so requester 0 wins first.
      req = 4'b0010;
      step();
      chk_grant("to_prep", 4'b0010, 2'd1);
      req = 4'b0000;
      step();
      chk_idle("to_prep_idle");
      req = 4'b0011;
      for (int c = 0; c < 4; c++) begin
         step();
         chk_grant("to_owner0", 4'b0001, 2'd0);
      end
      step();
      chk_idle("to_gap0");
      for (int c = 0; c < 4; c++) begin
         step();
         chk_grant("to_owner1", 4'b0010, 2'd1);
      end
      step();
      chk_idle("to_gap1");
      step();
      chk_grant("to_owner0_again", 4'b0001, 2'd0);
      req = 4'b0000;
      step();
      chk_idle("to_done");
`else
      // Without the timeout, the grant is held for as long as the request stays high.
      req = 4'b0001;
      for (int c = 0; c < 100; c++) begin
         step();
         chk_grant("notimeout_hold", 4'b0001, 2'd0);
      end
      req = 4'b0000;
      step();
      chk_idle("notimeout_release");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter that owns the select/enable pair of a 2-to-4 decoder stage. It sequences access to one shared resource. It produces a registered 2-bit grant index plus a grant-valid that drive the decoder's `A`/`En` inputs, and it also outputs the equivalent one-hot grant directly. A grant is held until the owner releases its request, with an optional hold-time limit.

## Interface

Parameters:
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per owner when the timeout feature is compiled in. Legal range 2..256. Ignored otherwise.

Ports:
- `clk`  input  1: single clock; all state updates on rising edge.
- `rst_n`  input  1: reset is asynchronous and active-low.
- `req`  input  4: request lines; bit i = requester i.
- `gnt`  output  4: one-hot grant, registered; all-zero when no grant.
- `gnt_idx`  output  2: binary index of the current owner; drives decoder `A`.
- `gnt_valid`  output  1: a grant is active; drives decoder `En`.

## Operation

- State machine with two states:
  - IDLE: `gnt_valid`=0.
  - GRANT: `gnt_valid`=1, `gnt`=one-hot of `gnt_idx`.
- Round-robin pointer `last` (2 bits) records the most recent owner.
- Search order starts at `last+1` (mod 4) and wraps: `last+1`, `last+2`, `last+3`, `last`.
- IDLE transitions:
  - Any `req` bit set: select the first set bit in search order, load `gnt_idx`, set `last` to that index, go to GRANT.
  - `req`=0000: stay in IDLE.
- GRANT transitions:
  - `req[gnt_idx]`=1: stay in GRANT; `gnt_idx` does not change.
  - `req[gnt_idx]`=0: go to IDLE. `gnt` clears on that edge.
- Other requests never preempt the current owner. Changes on non-owner `req` bits during GRANT are ignored.
- There is exactly one IDLE cycle between consecutive grants. A handover is never back-to-back.
- A requester that releases and re-asserts competes normally. It has lowest priority on the next arbitration because it is `last`.
- Reset values:
  - Outputs: `gnt`=0000, `gnt_idx`=00, `gnt_valid`=0.
  - Internal: state IDLE, `last`=11 (so requester 0 has first priority), hold counter 0.
- Reset asserted mid-grant clears all outputs immediately, without waiting for a clock edge.
- `gnt`, `gnt_idx` and `gnt_valid` always change on the same edge. `gnt` == decode(`gnt_idx`) gated by `gnt_valid` at all times.

## Timing

- Request-to-grant latency: `req` sampled at edge n while in IDLE gives `gnt` valid after edge n. That is one cycle, registered.
- Release-to-deassert latency: owner's `req` sampled low at edge m gives `gnt`=0000 after edge m.
- Next grant after release: valid after edge m+1, if another request is pending at edge m+1.
- Outputs are driven only from flops. There is no combinational path from `req` to any output.
- If all four `req` bits are held high and each owner releases after k grant cycles, each requester gets one turn per 4(k+1) cycles.

## Configuration

- Macro: `RR_ARBITER4_TIMEOUT_EN`.
- Defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the counter equals `MAX_HOLD`-1 and the owner's `req` is still high, the next edge forces IDLE and clears `gnt`.
  - `last` keeps the preempted owner, so it goes to the back of the search order.
  - Result: the maximum continuous grant is exactly `MAX_HOLD` cycles.
- Undefined:
  - No counter logic is present.
  - A grant is held indefinitely while the owner's `req` stays high.

## Test plan

- Reset: drive `rst_n`=0 mid-grant with `req`=1111.
  - `gnt`=0000, `gnt_idx`=00 and `gnt_valid`=0 immediately.
  - After release with `req`=1111, the first grant is `gnt`=0001.
- Single request: `req`=0100 at edge 0.
  - `gnt`=0100, `gnt_idx`=10, `gnt_valid`=1 after edge 0, held while `req[2]`=1.
  - Drop `req[2]`: `gnt`=0000 one edge later.
- Fairness: `req`=1111 continuously, with each owner dropping its bit for one cycle after 2 grant cycles.
  - Grant sequence is 0001, 0010, 0100, 1000, 0001, each separated by one 0000 cycle.
- No preemption: during a grant to 0010, toggle `req[0]`.
  - `gnt` stays 0010 until `req[1]`=0.
  - Then 0000 for one cycle, then 0001 if `req[0]`=1.
- Timeout (macro defined, `MAX_HOLD`=4): `req`=0011 held constant.
  - `gnt`=0001 for 4 cycles, 0000 for 1, 0010 for 4, 0000 for 1, 0001 again.
- No timeout (macro undefined): `req`=0001 held for 100 cycles.
  - `gnt`=0001 for all 100 cycles.
